// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder for the bit-serial pattern detector: accepts words on a
// valid/ready handshake and streams them out one bit per clock, back to back without gaps.
module serial_word_feeder #(
  parameter int unsigned DATA_W    = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        IDLE_BIT  = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              x,
  output logic              x_valid,
  output logic              word_done,
  output logic              busy
);

  localparam int unsigned       CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DATA_W - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] sreg, sreg_nx;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nx;
  logic              x_nx, x_valid_nx;
  logic              last_bit, accept;

  function automatic logic lead_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  assign last_bit  = (state == SHIFT) && (bit_cnt == LAST);
  assign word_done = last_bit;
  assign in_ready  = reset_n && ((state == IDLE) || last_bit);
  assign accept    = in_valid && in_ready;

  // sreg keeps the bit currently on x at its lead position; x is that bit, registered.
  always_comb begin
    state_nx   = state;
    sreg_nx    = sreg;
    bit_cnt_nx = bit_cnt;
    x_nx       = x;
    x_valid_nx = x_valid;
    if (accept) begin
      state_nx   = SHIFT;
      sreg_nx    = in_data;
      bit_cnt_nx = '0;
      x_nx       = lead_bit(in_data);
      x_valid_nx = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          x_nx       = IDLE_BIT;
          x_valid_nx = 1'b0;
        end
        SHIFT: begin
          if (!last_bit) begin
            sreg_nx    = advance(sreg);
            bit_cnt_nx = bit_cnt + CNT_W'(1);
            x_nx       = lead_bit(advance(sreg));
          end else begin
            state_nx   = IDLE;
            bit_cnt_nx = '0;
            x_nx       = IDLE_BIT;
            x_valid_nx = 1'b0;
          end
        end
        default: begin
          state_nx   = IDLE;
          x_nx       = IDLE_BIT;
          x_valid_nx = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      sreg    <= '0;
      bit_cnt <= '0;
      x       <= IDLE_BIT;
      x_valid <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      sreg    <= sreg_nx;
      bit_cnt <= bit_cnt_nx;
      x       <= x_nx;
      x_valid <= x_valid_nx;
      busy    <= (state_nx == SHIFT);
    end
  end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder: three configurations checked every cycle against a
// remaining-bits model, plus literal checks of the captured serial streams.
module tb_serial_word_feeder;

  logic       clk;
  logic [2:0] rst;
  logic [7:0] in_data [3];
  logic       in_valid [3];
  logic       in_ready [3];
  logic       x [3];
  logic       x_valid [3];
  logic       word_done [3];
  logic       busy [3];

  int compared;
  int mismatched;

  // model: word in flight and how many of its bits are still to appear on x
  logic [7:0] m_word [3];
  int         m_rem [3];

  logic [15:0] cap [3];
  int          ncap [3];
  int          wd [3];

  serial_word_feeder #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (
    .clk(clk), .reset_n(rst[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .x(x[0]), .x_valid(x_valid[0]), .word_done(word_done[0]),
    .busy(busy[0]));

  serial_word_feeder #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_b (
    .clk(clk), .reset_n(rst[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .x(x[1]), .x_valid(x_valid[1]), .word_done(word_done[1]),
    .busy(busy[1]));

  serial_word_feeder #(.DATA_W(2), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_c (
    .clk(clk), .reset_n(rst[2]), .in_data(in_data[2][1:0]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .x(x[2]), .x_valid(x_valid[2]), .word_done(word_done[2]),
    .busy(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int w_of(input int d);
    return (d == 2) ? 2 : 8;
  endfunction
  function automatic bit msb_of(input int d);
    return d != 1;
  endfunction
  function automatic logic idle_of(input int d);
    return (d == 1) ? 1'b1 : 1'b0;
  endfunction

  function automatic logic e_valid(input int d);
    return rst[d] && (m_rem[d] > 0);
  endfunction
  function automatic logic e_ready(input int d);
    return rst[d] && (m_rem[d] <= 1);
  endfunction
  function automatic logic e_done(input int d);
    return rst[d] && (m_rem[d] == 1);
  endfunction
  function automatic logic e_x(input int d);
    int pos;
    if (!e_valid(d)) return idle_of(d);
    pos = msb_of(d) ? (m_rem[d] - 1) : (w_of(d) - m_rem[d]);
    return m_word[d][pos];
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst[d]) begin
        m_rem[d] = 0;
      end else begin
        bit acc;
        acc = in_valid[d] && (m_rem[d] <= 1);
        if (m_rem[d] > 0) m_rem[d] = m_rem[d] - 1;
        if (acc) begin
          m_word[d] = in_data[d];
          m_rem[d]  = w_of(d);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("dut%0d x", d), 16'(x[d]), 16'(e_x(d)));
      chk($sformatf("dut%0d x_valid", d), 16'(x_valid[d]), 16'(e_valid(d)));
      chk($sformatf("dut%0d word_done", d), 16'(word_done[d]), 16'(e_done(d)));
      chk($sformatf("dut%0d in_ready", d), 16'(in_ready[d]), 16'(e_ready(d)));
      chk($sformatf("dut%0d busy", d), 16'(busy[d]), 16'(e_valid(d)));
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst[d] && x_valid[d]) begin
        cap[d]  = {cap[d][14:0], x[d]};
        ncap[d] = ncap[d] + 1;
        if (word_done[d]) wd[d] = wd[d] + 1;
      end
    end
  end

  task automatic clr(input int d);
    cap[d]  = '0;
    ncap[d] = 0;
    wd[d]   = 0;
  endtask

  // present a word and hold it until the model says it will be taken on the next edge
  task automatic push(input int d, input logic [7:0] w);
    bit ok;
    ok = 1'b0;
    in_data[d]  = w;
    in_valid[d] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (e_ready(d)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL push timeout dut%0d: got no ready expected ready", d);
    end
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 3'b000;
    for (int d = 0; d < 3; d++) begin
      in_data[d]  = '0;
      in_valid[d] = 1'b0;
      m_word[d]   = '0;
      m_rem[d]    = 0;
      clr(d);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 3'b111;
    @(posedge clk);
    #1;

    // single word, MSB first
    clr(0);
    push(0, 8'b1011_0110);
    repeat (10) @(posedge clk);
    #1;
    chk("t1 stream", cap[0], 16'h00B6);
    chk("t1 bits", 16'(ncap[0]), 16'd8);
    chk("t1 word_done", 16'(wd[0]), 16'd1);

    // back to back
    clr(0);
    push(0, 8'hFF);
    push(0, 8'h00);
    repeat (10) @(posedge clk);
    #1;
    chk("t2 stream", cap[0], 16'hFF00);
    chk("t2 bits", 16'(ncap[0]), 16'd16);
    chk("t2 word_done", 16'(wd[0]), 16'd2);

    // LSB first with idle level 1
    clr(1);
    push(1, 8'h01);
    repeat (10) @(posedge clk);
    #1;
    chk("t3 stream", cap[1], 16'h0080);
    chk("t3 idle x", 16'(x[1]), 16'd1);
    chk("t3 idle x_valid", 16'(x_valid[1]), 16'd0);

    // word offered mid-stream, plus one withdrawn offer
    clr(0);
    push(0, 8'h3C);
    @(posedge clk);
    #1;
    in_data[0]  = 8'h77;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    push(0, 8'hA5);
    repeat (12) @(posedge clk);
    #1;
    chk("t4 stream", cap[0], 16'h3CA5);
    chk("t4 bits", 16'(ncap[0]), 16'd16);
    chk("t4 word_done", 16'(wd[0]), 16'd2);

    // reset mid-word
    clr(0);
    push(0, 8'hF0);
    repeat (4) @(posedge clk);
    #2;
    rst[0] = 1'b0;
    #1;
    chk("t5 async x", 16'(x[0]), 16'd0);
    chk("t5 async x_valid", 16'(x_valid[0]), 16'd0);
    chk("t5 async in_ready", 16'(in_ready[0]), 16'd0);
    @(posedge clk);
    #1;
    rst[0] = 1'b1;
    chk("t5 no word_done", 16'(wd[0]), 16'd0);
    clr(0);
    push(0, 8'h81);
    repeat (10) @(posedge clk);
    #1;
    chk("t5 stream", cap[0], 16'h0081);
    chk("t5 word_done", 16'(wd[0]), 16'd1);

    // two-bit words
    clr(2);
    push(2, 8'h02);
    push(2, 8'h03);
    repeat (5) @(posedge clk);
    #1;
    chk("t6 stream", cap[2], 16'h000B);
    chk("t6 bits", 16'(ncap[2]), 16'd4);
    chk("t6 word_done", 16'(wd[2]), 16'd2);

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
